lut_layer_scheduler: RTL and testbench

Time-multiplexed evaluator for one LogicNets-style layer of 6-input, 1-output LUT neurons. Holds a run-time-programmable truth table and fan-in connectivity map for each neuron. For every accepted input feature vector it walks all neurons one per cycle through a single shared LUT read path and assembles the output bit vector. It sits between the input quantiser and the next layer, replacing NUM_NEURONS fixed ROM instances when area matters more than latency.

---
 rtl/lut_sched_pkg.sv | 23 ++
 rtl/lut_neuron_bank.sv | 66 ++++++
 rtl/lut_layer_scheduler.sv | 139 +++++++++++++
 tb/tb_lut_layer_scheduler.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_sched_pkg.sv
// Shared types and helpers for the time-multiplexed LUT layer scheduler.
// The map-field helper pulls one fan-in index out of a packed connectivity word.
package lut_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned MAP_MAX = 256;

   function automatic int unsigned tt_width(input int unsigned fanin);
      return 32'd1 << fanin;
   endfunction

   function automatic logic [31:0] map_field(input logic [MAP_MAX-1:0] map,
                                             input int unsigned       j,
                                             input int unsigned       w);
      return 32'(map >> (j * w)) & ((32'd1 << w) - 32'd1);
   endfunction

endpackage

// File: rtl/lut_neuron_bank.sv
// Truth-table and fan-in map storage for every neuron, with a single
// combinational read port that evaluates one neuron against a vector.
module lut_neuron_bank
   import lut_sched_pkg::*;
#(
   parameter int unsigned NUM_NEURONS = 16,
   parameter int unsigned FANIN       = 6,
   parameter int unsigned IN_WIDTH    = 32,
   parameter int unsigned IDX_W       = $clog2(IN_WIDTH),
   parameter int unsigned NID_W       = $clog2(NUM_NEURONS),
   parameter int unsigned TT_W        = tt_width(FANIN),
   parameter int unsigned MAP_W       = FANIN * IDX_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                tt_we,
   input  logic                map_we,
   input  logic [NID_W-1:0]    wr_nid,
   input  logic [TT_W-1:0]     tt_data,
   input  logic [MAP_W-1:0]    map_data,
   input  logic [NID_W-1:0]    rd_nid,
   input  logic [IN_WIDTH-1:0] rd_vec,
   output logic                rd_bit
);

   logic [TT_W-1:0]  tt_r  [NUM_NEURONS];
   logic [MAP_W-1:0] map_r [NUM_NEURONS];

   logic [MAP_W-1:0] rd_map_s;
   logic [IDX_W-1:0] idx_s;
   logic [FANIN-1:0] addr_s;

   // Table storage: cleared on reset, written only with pre-qualified strobes
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_NEURONS; k++) begin
            tt_r[k]  <= '0;
            map_r[k] <= '0;
         end
      end else begin
         if (tt_we) begin
            tt_r[wr_nid] <= tt_data;
         end
         if (map_we) begin
            map_r[wr_nid] <= map_data;
         end
      end
   end

   // Shared read path: gather the address through the map, then look up the table
   always_comb begin
      rd_map_s = map_r[rd_nid];
      idx_s    = '0;
      addr_s   = '0;
      for (int j = 0; j < FANIN; j++) begin
         idx_s = IDX_W'(map_field(MAP_MAX'(rd_map_s), j, IDX_W));
         if (32'(idx_s) < IN_WIDTH) begin
            addr_s[j] = rd_vec[idx_s];
         end else begin
            addr_s[j] = 1'b0;
         end
      end
      rd_bit = tt_r[rd_nid][addr_s];
   end

endmodule

// File: rtl/lut_layer_scheduler.sv
// One LogicNets-style layer evaluated one neuron per cycle through a shared
// LUT read path; handles the input/output handshakes and runtime config writes.
module lut_layer_scheduler
   import lut_sched_pkg::*;
#(
   parameter int unsigned NUM_NEURONS = 16,
   parameter int unsigned FANIN       = 6,
   parameter int unsigned IN_WIDTH    = 32,
   parameter int unsigned IDX_W       = $clog2(IN_WIDTH),
   parameter int unsigned NID_W       = $clog2(NUM_NEURONS),
   parameter int unsigned TT_W        = tt_width(FANIN),
   parameter int unsigned MAP_W       = FANIN * IDX_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [IN_WIDTH-1:0]    in_vec,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [NUM_NEURONS-1:0] out_vec,
   input  logic                   tt_we,
   input  logic                   map_we,
   input  logic [NID_W-1:0]       cfg_nid,
   input  logic [TT_W-1:0]        tt_data,
   input  logic [MAP_W-1:0]       map_data,
   output logic                   cfg_err
);

   state_t                   state_r;
   logic [NID_W-1:0]         cnt_r;
   logic [IN_WIDTH-1:0]      in_vec_q_r;
   logic [NUM_NEURONS-1:0]   out_vec_r;
   logic                     out_valid_r;
   logic                     cfg_err_r;

   logic                     in_ready_s;
   logic                     accept_s;
   logic                     last_s;
   logic                     cfg_req_s;
   logic                     nid_ok_s;
   logic                     cfg_ok_s;
   logic                     bank_bit_s;

   // A power-of-two layer cannot be addressed out of range
   if (NUM_NEURONS == (32'd1 << NID_W)) begin : g_nid_full
      assign nid_ok_s = 1'b1;
   end else begin : g_nid_part
      assign nid_ok_s = (32'(cfg_nid) < NUM_NEURONS);
   end

   assign cfg_req_s  = tt_we | map_we;
   assign cfg_ok_s   = (state_r == IDLE) & nid_ok_s;
   assign in_ready_s = rst_n & ((state_r == IDLE) | ((state_r == DONE) & out_ready));
   assign accept_s   = in_valid & in_ready_s;
   assign last_s     = (cnt_r == NID_W'(NUM_NEURONS - 1));

   lut_neuron_bank #(
      .NUM_NEURONS (NUM_NEURONS),
      .FANIN       (FANIN),
      .IN_WIDTH    (IN_WIDTH),
      .IDX_W       (IDX_W),
      .NID_W       (NID_W),
      .TT_W        (TT_W),
      .MAP_W       (MAP_W)
   ) u_bank (
      .clk      (clk),
      .rst_n    (rst_n),
      .tt_we    (tt_we & cfg_ok_s),
      .map_we   (map_we & cfg_ok_s),
      .wr_nid   (cfg_nid),
      .tt_data  (tt_data),
      .map_data (map_data),
      .rd_nid   (cnt_r),
      .rd_vec   (in_vec_q_r),
      .rd_bit   (bank_bit_s)
   );

   // Control FSM with neuron counter, output vector register and config error pulse
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         cnt_r       <= '0;
         in_vec_q_r  <= '0;
         out_vec_r   <= '0;
         out_valid_r <= 1'b0;
         cfg_err_r   <= 1'b0;
      end else begin
         cfg_err_r <= cfg_req_s & ~cfg_ok_s;
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  in_vec_q_r <= in_vec;
                  cnt_r      <= '0;
                  state_r    <= BUSY;
               end else begin
                  state_r    <= IDLE;
               end
            end
            BUSY: begin
               out_vec_r[cnt_r] <= bank_bit_s;
               if (last_s) begin
                  cnt_r       <= '0;
                  out_valid_r <= 1'b1;
                  state_r     <= DONE;
               end else begin
                  cnt_r       <= cnt_r + NID_W'(1);
                  state_r     <= BUSY;
               end
            end
            DONE: begin
               // Handoff: result leaves and the next vector enters on the same edge
               if (accept_s) begin
                  in_vec_q_r  <= in_vec;
                  cnt_r       <= '0;
                  out_valid_r <= 1'b0;
                  state_r     <= BUSY;
               end else if (out_ready) begin
                  out_valid_r <= 1'b0;
                  state_r     <= IDLE;
               end else begin
                  state_r     <= DONE;
               end
            end
            default: begin
               cnt_r       <= '0;
               out_valid_r <= 1'b0;
               state_r     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_r;
   assign out_vec   = out_vec_r;
   assign cfg_err   = cfg_err_r;

endmodule

// File: tb/tb_lut_layer_scheduler.sv
// Directed self-checking bench for lut_layer_scheduler: a 16-neuron layer plus
// a 12-neuron/24-bit instance for out-of-range neuron ids and map indices.
module tb_lut_layer_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_vec;
   logic [15:0] out_vec;
   logic        tt_we, map_we, cfg_err;
   logic [3:0]  cfg_nid;
   logic [63:0] tt_data;
   logic [29:0] map_data;

   logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
   logic [23:0] s_in_vec;
   logic [11:0] s_out_vec;
   logic        s_tt_we, s_map_we, s_cfg_err;
   logic [3:0]  s_cfg_nid;
   logic [63:0] s_tt_data;
   logic [29:0] s_map_data;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   lut_layer_scheduler u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_vec(in_vec), .out_valid(out_valid), .out_ready(out_ready),
      .out_vec(out_vec), .tt_we(tt_we), .map_we(map_we), .cfg_nid(cfg_nid),
      .tt_data(tt_data), .map_data(map_data), .cfg_err(cfg_err)
   );

   lut_layer_scheduler #(.NUM_NEURONS(12), .IN_WIDTH(24)) u_small (
      .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_vec(s_in_vec), .out_valid(s_out_valid), .out_ready(s_out_ready),
      .out_vec(s_out_vec), .tt_we(s_tt_we), .map_we(s_map_we), .cfg_nid(s_cfg_nid),
      .tt_data(s_tt_data), .map_data(s_map_data), .cfg_err(s_cfg_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input logic [31:0] v, output logic [15:0] res, output int lat);
      in_vec   = v;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      res = out_vec;
      tick();
   endtask

   task automatic cfg(input logic [3:0] nid, input logic [63:0] tt, input logic [29:0] mp,
                      input logic wt, input logic wm);
      cfg_nid = nid; tt_data = tt; map_data = mp; tt_we = wt; map_we = wm;
      tick();
      tt_we = 1'b0; map_we = 1'b0;
      checks++;
      if (cfg_err !== 1'b0) begin
         errors++;
         $display("FAIL cfg_ok_no_err got=%b exp=0", cfg_err);
      end
   endtask

   task automatic test_reset();
      logic [15:0] res;
      int lat;
      rst_n = 1'b0;
      tick();
      tick();
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready_low got=%b exp=0", in_ready); end
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
      checks++;
      if (out_vec !== 16'h0000) begin errors++; $display("FAIL rst_out_vec got=%h exp=0000", out_vec); end
      checks++;
      if (cfg_err !== 1'b0) begin errors++; $display("FAIL rst_cfg_err got=%b exp=0", cfg_err); end
      run_vec(32'hFFFF_FFFF, res, lat);
      checks++;
      if (res !== 16'h0000) begin errors++; $display("FAIL unprogrammed got=%h exp=0000", res); end
      checks++;
      if (lat !== 16) begin errors++; $display("FAIL unprog_latency got=%0d exp=16", lat); end
   endtask

   task automatic test_single_neuron();
      logic [15:0] res;
      int lat;
      cfg(4'd3, 64'h8000_0000_0000_0000, {5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0}, 1'b1, 1'b1);
      run_vec(32'h0000_003F, res, lat);
      checks++;
      if (res !== 16'h0008) begin errors++; $display("FAIL single_3f got=%h exp=0008", res); end
      checks++;
      if (lat !== 16) begin errors++; $display("FAIL single_latency got=%0d exp=16", lat); end
      run_vec(32'h0000_003E, res, lat);
      checks++;
      if (res !== 16'h0000) begin errors++; $display("FAIL single_3e got=%h exp=0000", res); end
   endtask

   task automatic test_map_routing();
      logic [15:0] res;
      int lat;
      cfg(4'd0, 64'h0000_0000_0000_0002, {5'd8, 5'd8, 5'd8, 5'd8, 5'd8, 5'd31}, 1'b1, 1'b1);
      run_vec(32'h8000_0000, res, lat);
      checks++;
      if (res !== 16'h0001) begin errors++; $display("FAIL route_bit31 got=%h exp=0001", res); end
      run_vec(32'h0000_0001, res, lat);
      checks++;
      if (res !== 16'h0000) begin errors++; $display("FAIL route_bit0 got=%h exp=0000", res); end
   endtask

   task automatic test_back_to_back();
      int lat;
      out_ready = 1'b0;
      in_vec    = 32'h0000_003F;
      in_valid  = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
      checks++;
      if (lat !== 16 || out_vec !== 16'h0008) begin
         errors++; $display("FAIL bp_first got lat=%0d vec=%h exp lat=16 vec=0008", lat, out_vec);
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_vec !== 16'h0008 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold cyc=%0d got valid=%b vec=%h rdy=%b exp 1/0008/0", i, out_valid, out_vec, in_ready);
         end
      end
      in_vec    = 32'h8000_0000;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL handoff_ready got=%b exp=1", in_ready); end
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL handoff_busy got=%b exp=0", out_valid); end
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
      checks++;
      if (lat !== 16) begin errors++; $display("FAIL b2b_latency got=%0d exp=16", lat); end
      checks++;
      if (out_vec !== 16'h0001) begin errors++; $display("FAIL b2b_result got=%h exp=0001", out_vec); end
      tick();
   endtask

   task automatic test_cfg_reject();
      logic [15:0] res;
      int lat;
      in_vec   = 32'h0000_003F;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      cfg_nid = 4'd3; tt_data = 64'h0; tt_we = 1'b1;
      tick();
      tt_we = 1'b0;
      checks++;
      if (cfg_err !== 1'b1) begin errors++; $display("FAIL busy_write_err got=%b exp=1", cfg_err); end
      tick();
      checks++;
      if (cfg_err !== 1'b0) begin errors++; $display("FAIL busy_err_pulse got=%b exp=0", cfg_err); end
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
      checks++;
      if (out_vec !== 16'h0008) begin errors++; $display("FAIL busy_write_dropped got=%h exp=0008", out_vec); end
      cfg_nid = 4'd0; map_data = 30'h0; map_we = 1'b1;
      tick();
      map_we = 1'b0;
      checks++;
      if (cfg_err !== 1'b1) begin errors++; $display("FAIL done_write_err got=%b exp=1", cfg_err); end
      tick();
      run_vec(32'h8000_003F, res, lat);
      checks++;
      if (res !== 16'h0009) begin errors++; $display("FAIL cfg_unchanged got=%h exp=0009", res); end
   endtask

   task automatic test_small_layer();
      int lat;
      s_cfg_nid = 4'd12; s_tt_data = 64'hFFFF_FFFF_FFFF_FFFF; s_tt_we = 1'b1;
      tick();
      s_tt_we = 1'b0;
      checks++;
      if (s_cfg_err !== 1'b1) begin errors++; $display("FAIL bad_nid_err got=%b exp=1", s_cfg_err); end
      tick();
      checks++;
      if (s_cfg_err !== 1'b0) begin errors++; $display("FAIL bad_nid_pulse got=%b exp=0", s_cfg_err); end
      for (int pass = 0; pass < 2; pass++) begin
         s_cfg_nid  = 4'd0;
         s_tt_data  = 64'h8000_0000_0000_0000;
         s_map_data = (pass == 0) ? {25'd0, 5'd31} : {25'd0, 5'd23};
         s_tt_we = 1'b1; s_map_we = 1'b1;
         tick();
         s_tt_we = 1'b0; s_map_we = 1'b0;
         s_in_vec = 24'hFF_FFFF; s_in_valid = 1'b1;
         tick();
         s_in_valid = 1'b0;
         lat = 0;
         while (s_out_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
         checks++;
         if (lat !== 12) begin errors++; $display("FAIL small_latency got=%0d exp=12", lat); end
         checks++;
         if (s_out_vec !== ((pass == 0) ? 12'h000 : 12'h001)) begin
            errors++; $display("FAIL small_idx pass=%0d got=%h exp=%h", pass, s_out_vec, (pass == 0) ? 12'h000 : 12'h001);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] res;
      int lat;
      logic seen;
      in_vec   = 32'h0000_003F;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (6) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (out_valid === 1'b1) seen = 1'b1;
         tick();
      end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL mid_rst_no_valid got=%b exp=0", seen); end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_idle got=%b exp=1", in_ready); end
      run_vec(32'h0000_003F, res, lat);
      checks++;
      if (res !== 16'h0000) begin errors++; $display("FAIL mid_rst_tt_cleared got=%h exp=0000", res); end
      run_vec(32'h8000_0000, res, lat);
      checks++;
      if (res !== 16'h0000) begin errors++; $display("FAIL mid_rst_n0_cleared got=%h exp=0000", res); end
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_vec = 32'h0; out_ready = 1'b1;
      tt_we = 1'b0; map_we = 1'b0; cfg_nid = 4'd0; tt_data = 64'h0; map_data = 30'h0;
      s_in_valid = 1'b0; s_in_vec = 24'h0; s_out_ready = 1'b1;
      s_tt_we = 1'b0; s_map_we = 1'b0; s_cfg_nid = 4'd0; s_tt_data = 64'h0; s_map_data = 30'h0;
      test_reset();
      test_single_neuron();
      test_map_routing();
      test_back_to_back();
      test_cfg_reject();
      test_small_layer();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
